// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and FSM state encoding for the UART receive
//            path (uart_rx_byte, uart_sync2, and future transmitter loopback).
// Contents : UART_DATA_BITS, UART_IDLE_LEVEL, uart_state_t, ST_* state codes.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef logic [2:0] uart_state_t;

  // PARITY keeps its code in every build so encodings stay stable across
  // configurations (useful when comparing traces between builds).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Purpose  : Two-flop synchroniser for an asynchronous serial line. Both
//            flops reset to the UART idle level so that a reset never looks
//            like a start bit to downstream logic.
// Ports    : clk   in  system clock
//            rst_n in  asynchronous active-low reset
//            d     in  asynchronous input
//            q     out synchronised output
// Revision : 1.0  initial release
// ============================================================================
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= UART_IDLE_LEVEL;
      r_sync <= UART_IDLE_LEVEL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined).
//            Mid-bit sampling from a bit-period counter, stop/parity checking,
//            and a one-byte holding register with a valid/ready handshake.
// Params   : CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//            CNT_W         counter width, 2**CNT_W > CLKS_PER_BIT
// Ports    : clk          in   system clock
//            rst_n        in   asynchronous active-low reset
//            uart_rxd     in   serial line, idle high, asynchronous
//            rx_enable    in   accept new frames (looked at in IDLE only)
//            rx_ready     in   consumer takes byte when rx_valid=1
//            rx_data_out  out  received byte, LSB first on the wire
//            rx_valid     out  holding register full
//            frame_err    out  1-cycle pulse: bad stop/parity, byte dropped
//            overrun      out  1-cycle pulse: register full, new byte dropped
// Macro    : UART_RX_PARITY_EN  adds an even-parity bit between data and stop
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rxd,
  input  logic                      rx_enable,
  input  logic                      rx_ready,
  output logic [UART_DATA_BITS-1:0] rx_data_out,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int               c_idx_w    = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(UART_DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_after_data = ST_PARITY;
`else
  localparam logic [2:0] c_after_data = ST_STOP;
`endif

  logic                      w_rxs;
  logic                      w_par_err;
  uart_state_t               r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [c_idx_w-1:0]        r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_overrun;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rxd),
    .q     (w_rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumer handshake; a delivery later in this block overrides it.
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_enable && (w_rxs != UART_IDLE_LEVEL)) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end

        ST_START: begin
          if (r_cnt == c_half_last) begin
            r_cnt <= '0;
            if (w_rxs == UART_IDLE_LEVEL) begin
              r_state <= ST_IDLE;              // glitch, not a real start bit
            end else begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt     <= '0;
            r_shift   <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == c_idx_last) begin
              r_state <= c_after_data;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == c_bit_last) begin
            r_cnt     <= '0;
            r_par_err <= ^{r_shift, w_rxs};    // even parity over data+parity
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (r_cnt == c_bit_last) begin
            r_cnt <= '0;
            if (w_rxs != UART_IDLE_LEVEL) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;     // line held low: maybe a break
            end else if (w_par_err) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_IDLE;
              if (!r_valid || rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          if (w_rxs == UART_IDLE_LEVEL) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data_out = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_byte
// Purpose  : Self-checking bench for uart_rx_byte (CLKS_PER_BIT=16). Frames
//            are built bit by bit on the line; a transaction-level model
//            predicts, per clock, the holding register and error pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_byte;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Edges from the line change (at a negedge) to the stop-sample edge:
  // 2 synchroniser edges, 1 IDLE detect edge, half a bit, 8 data bits,
  // optional parity bit, stop bit.
  localparam int SAMPLE_OFS = 3 + H + (9 + PAR) * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_enable = 1'b1;
  logic       rx_ready;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  logic ready_reg = 1'b1;
  logic ready_rand_en = 1'b0;
  logic ready_rand = 1'b0;
  assign rx_ready = ready_rand_en ? ready_rand : ready_reg;

  uart_rx_byte #(
    .CLKS_PER_BIT (C),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rxd    (uart_rxd),
    .rx_enable   (rx_enable),
    .rx_ready    (rx_ready),
    .rx_data_out (rx_data_out),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int unsigned cyc;
    bit          good;
    logic [7:0]  data;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  bit         mon_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      if (m_valid && rx_ready) m_valid = 1'b0;     // consumer took the byte
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (!ev.good)       m_ferr = 1'b1;
        else if (m_valid)   m_ovr  = 1'b1;         // still full: drop new byte
        else begin
          m_data  = ev.data;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("rx_valid", rx_valid, m_valid);
      check("rx_data_out", rx_data_out, m_data);
      check("frame_err", frame_err, m_ferr);
      check("overrun", overrun, m_ovr);
    end
  end

  always @(negedge clk) begin
    if (ready_rand_en) ready_rand = ($urandom_range(0, 3) == 0);
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bit,
                            input int stop_len, input int gap, input bit accept,
                            input bit drop_en_mid);
    ev_t e;
    logic par;
    par = (^d) ^ par_flip;
    if (accept) begin
      e.cyc  = cyc + SAMPLE_OFS;
      e.good = stop_bit && !(PAR == 1 && par_flip);
      e.data = d;
      evq.push_back(e);
    end
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) begin
      if (drop_en_mid && i == 2) rx_enable = 1'b0;
      drive(d[i], C);
    end
    if (PAR == 1) drive(par, C);
    if (drop_en_mid) rx_enable = 1'b1;
    drive(stop_bit, stop_len);
    drive(1'b1, gap);
  endtask

  initial begin
    logic [7:0] d;
    bit         bad_stop;
    bit         pflip;

    repeat (3) @(negedge clk);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data_out", rx_data_out, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 2 * C);

    // Good frame, consumer always ready.
    send_frame(8'hA5, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);

    // Short low glitch on the idle line.
    drive(1'b0, 4);
    drive(1'b1, 3 * C);

    // Broken stop bit (held low), then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 40, C, 1'b1, 1'b0);
    send_frame(8'h42, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);

    // Consumer stalled: second byte overruns, then release.
    ready_reg = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, C, 0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);
    ready_reg = 1'b1;
    drive(1'b1, 4);

    // Receiver disabled, then re-enabled.
    rx_enable = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, C, 2 * C, 1'b0, 1'b0);
    rx_enable = 1'b1;
    send_frame(8'h56, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);

    // Reset in the middle of a frame while the holding register is full.
    ready_reg = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(8'h99 >> i, C);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    evq.delete();
    #1;
    check("async_rst_rx_valid", rx_valid, 1'b0);
    check("async_rst_rx_data_out", rx_data_out, 8'h00);
    check("async_rst_frame_err", frame_err, 1'b0);
    check("async_rst_overrun", overrun, 1'b0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    ready_reg = 1'b1;
    drive(1'b1, 2 * C);
    send_frame(8'h7E, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, C, 2 * C, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1, C, 2 * C, 1'b1, 1'b0);
`endif

    // Randomised frames, consumer readiness random each cycle.
    ready_rand_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      pflip    = (PAR == 1) && ($urandom_range(0, 4) == 0);
      send_frame(d, pflip, !bad_stop,
                 bad_stop ? C + int'($urandom_range(0, 2 * C)) : C,
                 int'($urandom_range(2, 8)), 1'b1, ($urandom_range(0, 3) == 0));
    end
    ready_rand_en = 1'b0;
    ready_reg     = 1'b1;
    drive(1'b1, 2 * C);
    check("events_pending", evq.size(), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver that deserialises the asynchronous serial input into bytes.
- Sits directly upstream of the SRAM command controller.
- Presents each received byte on an 8-bit holding register with a valid/ready handshake: rx_data_out/rx_valid out, rx_ready/rx_enable in.
- Oversamples with a bit-period counter, samples at mid-bit, checks the stop bit and flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per serial bit; minimum 4.
- CNT_W, 8, bit-counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- uart_rxd  in  1  serial line, idle high, asynchronous to clk
- rx_enable  in  1  1 = accept new frames; sampled only in IDLE
- rx_ready  in  1  consumer accepts byte when rx_valid=1 at the clk edge
- rx_data_out  out  8  received byte, LSB received first
- rx_valid  out  1  holding register full
- frame_err  out  1  one-cycle pulse: stop bit (or parity) bad, byte discarded
- overrun  out  1  one-cycle pulse: byte completed while holding register full, new byte dropped

Behaviour:
- Reset: rx_data_out=0, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1.
- Reset is asynchronous and may occur mid-frame; all state aborts immediately.
- Synchroniser: uart_rxd passes through two flops; all logic uses the synced value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: if rx_enable=1 and rxs=0, go to START with cnt=0.
  - rx_enable=0 ignores start edges. Deasserting rx_enable mid-frame does not abort the frame.
- START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample rxs.
  - rxs=1: false start (glitch), return to IDLE.
  - rxs=0: go to DATA with cnt=0, bit index=0.
- DATA: every CLKS_PER_BIT cycles sample rxs into a shift register, LSB first.
  - After bit index 7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs=1: frame good, deliver byte (see holding register), go to IDLE.
  - rxs=0: frame_err=1 for one cycle, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then IDLE. This prevents a break condition from being read as a start bit.
- Holding register:
  - Handshake fires on a clk edge with rx_valid=1 and rx_ready=1; rx_valid clears on that edge.
  - rx_ready may be driven combinationally from rx_valid.
- Delivery (in the cycle the stop bit is sampled good):
  - rx_valid=0: load byte; rx_valid=1 from the next cycle.
  - rx_valid=1 and rx_ready=1 in the same cycle: load new byte; rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: keep old byte, drop new one, overrun=1 for one cycle.
- Latency: from the first clk edge where the synchronised start edge is seen to rx_valid=1 is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, plus 2 synchroniser cycles from the pin.
- Counter: cnt resets to 0 on every sample point; no wrap beyond CLKS_PER_BIT-1.
- Error pulses are never asserted simultaneously with each other.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled CLKS_PER_BIT after the last data bit.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, STOP is still sampled; then frame_err pulses and the byte is discarded (go to WAIT_HIGH if stop=0, else IDLE).
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 framing only.
- Ports are identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (3-bit, includes PARITY code even when unused).
  - UART_DATA_BITS=8.
  - UART_IDLE_LEVEL=1'b1.
- Sub-module uart_sync2: 2-flop synchroniser with async reset value 1; reusable by the future transmitter loopback and test logic.

Test Plan (CLKS_PER_BIT=16):
- Frame 0xA5 (8N1), rx_ready tied 1 -> rx_valid high exactly one cycle with rx_data_out=0xA5; frame_err=overrun=0.
- 4-cycle low glitch on idle line -> START samples 1, FSM back to IDLE, no rx_valid, no frame_err.
- Frame 0x3C with stop bit driven 0 for 40 cycles, then line high, then frame 0x42 -> one frame_err pulse, no valid for 0x3C, WAIT_HIGH exit, rx_data_out=0x42 valid.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data_out stays 0x11 with rx_valid=1; overrun pulse at 0x22 stop sample; raise rx_ready -> rx_valid drops next edge.
- rx_enable=0, frame 0x55 -> no valid, no errors; raise rx_enable, frame 0x56 -> received correctly.
- Assert rst_n low mid-DATA of 0x99 -> all outputs 0 immediately; after release, frame 0x7E received correctly.
- With UART_RX_PARITY_EN: frame 0x03 with parity bit 1 -> frame_err pulse, no valid; parity bit 0 -> 0x03 valid.
